// File: rtl/expr_eval_if.sv
// Request/response bundle between requesters, the
// shared evaluator arbiter and the response consumer.
interface expr_eval_if #(
  parameter int NREQ = 4,
  parameter int OPW  = 60,
  parameter int RESW = 90
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_operands;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [RESW-1:0]     rsp_result;

  modport slave (
    input  req_valid,
    input  req_operands,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_id,
    output rsp_result
  );

  modport master (
    output req_valid,
    output req_operands,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_result
  );
endinterface

// File: rtl/expr_eval_arbiter.sv
// Round-robin sharing of one combinational expression
// evaluator among NREQ requesters, one job in flight.
module expr_eval_arbiter #(
  parameter int NREQ        = 4,
  parameter int OPW         = 60,
  parameter int RESW        = 90,
  parameter int EVAL_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  expr_eval_if.slave      bus,
  output logic [OPW-1:0]  dp_operands,
  input  logic [RESW-1:0] dp_result,
  output logic            busy
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(EVAL_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] gidx;
  logic [IDW-1:0] j;
  logic           found;

  // First pending requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && bus.req_valid[j]) begin
        found = 1'b1;
        gidx  = j;
      end
    end
  end

  assign bus.req_ready =
    (!reset && state == IDLE && found) ?
    (NREQ'(1) << gidx) : '0;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      id             <= '0;
      cnt            <= '0;
      dp_operands    <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= '0;
      bus.rsp_result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            dp_operands <=
              bus.req_operands[int'(gidx)*OPW +: OPW];
            id    <= gidx;
            cnt   <= CW'(EVAL_CYCLES - 1);
            state <= EVAL;
          end
        end
        EVAL: begin
          if (cnt == '0) begin
            bus.rsp_result <= dp_result;
            bus.rsp_id     <= id;
            bus.rsp_valid  <= 1'b1;
            state          <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            rr_ptr <= (id == IDW'(NREQ - 1)) ?
                      '0 : id + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
